mc_main_control: RTL and testbench

- Moore control FSM for the 32-bit multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives every datapath enable and mux select, including PCWrite, PCWriteCond and jr_control. The PC-enable combiner ORs these into the PC register write enable.
- Sits between the instruction register opcode/funct fields and the datapath.

---
 rtl/mc_main_control.sv | 171 +++++++++++++++++
 tb/tb_mc_main_control.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select from the current state only.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | post-reset, all outputs low
// FETCH   | read instruction, load IR, PC <= PC + 4
// DECODE  | compute branch target into ALUOut, dispatch on Op
// MEMADR  | effective address = A + sign-extended imm
// MEMRD   | read data memory at ALUOut
// MEMWB   | rt <= MDR
// MEMWR   | write B to data memory at ALUOut
// EXEC    | R-type ALU operation on A, B
// RWB     | rd <= ALUOut
// BRANCH  | compare A, B; PC <= ALUOut if equal
// JUMP    | PC <= jump target
// JR      | PC <= register A
// ADDIEX  | A + sign-extended imm
// ADDIWB  | rt <= ALUOut
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] FN_JR    = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       jr_control,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JR     = 4'd11,
    S_ADDIEX = 4'd12,
    S_ADDIWB = 4'd13
  } state_t;

  state_t state, next_state;

  assign State = state;

  // State register; reset clears to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW)   next_state = S_MEMADR;
        else if (Op == OP_RTYPE)          next_state = (Funct == FN_JR) ? S_JR : S_EXEC;
        else if (Op == OP_BEQ)            next_state = S_BRANCH;
        else if (Op == OP_J)              next_state = S_JUMP;
        else if (Op == OP_ADDI)           next_state = S_ADDIEX;
        else                              next_state = S_FETCH;  // undefined opcode: NOP
      end
      S_MEMADR: next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;  // writeback/PC states and illegal 14/15
    endcase
  end

  // Moore output decode; anything not set in a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    jr_control  = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JR: begin
        jr_control = 1'b1;
        PCSource   = 2'b11;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-instruction state sequences from a
// vector table, per-state expected outputs from a reference table, plus a
// hand-written asynchronous-reset sequence.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       PCWrite, PCWriteCond, jr_control, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int vectors     = 0;
  int miscompares = 0;

  mc_main_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .jr_control(jr_control),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, packed as
  // {PCWrite,PCWriteCond,jr_control,IorD,MemRead,MemWrite,IRWrite,
  //  MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  logic [16:0] out_tab [16];

  function automatic logic [16:0] mk(
    input logic pcw, pcwc, jr, iord, mr, mw, irw, m2r, rd, rw, asa,
    input logic [1:0] asb, aop, pcs);
    return {pcw, pcwc, jr, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  function automatic logic [16:0] actual();
    return {PCWrite, PCWriteCond, jr_control, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  len;
    logic [23:0] seq;   // first expected state in [23:20]
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [3:0] es);
    logic [16:0] act;
    logic [16:0] exp_o;
    act   = actual();
    exp_o = out_tab[es];
    vectors++;
    if (State !== es) begin
      miscompares++;
      $display("FAIL %s state: got %0d, expected %0d", name, State, es);
    end
    vectors++;
    if (act !== exp_o) begin
      miscompares++;
      $display("FAIL %s outputs in state %0d: got %05h, expected %05h", name, es, act, exp_o);
    end
    vectors++;
    if ((32'($countones({PCWrite, PCWriteCond, jr_control})) > 1) || (MemRead && MemWrite)) begin
      miscompares++;
      $display("FAIL %s exclusivity: pcw/pcwc/jr=%b%b%b mr/mw=%b%b", name,
               PCWrite, PCWriteCond, jr_control, MemRead, MemWrite);
    end
  endtask

  // Starts at a negedge with the DUT in FETCH; ends at the next FETCH.
  task automatic run_vec(input string name, input vec_t v);
    logic [23:0] s;
    Op    = v.op;
    Funct = v.funct;
    s     = v.seq;
    for (int i = 0; i < int'(v.len); i++) begin
      check(name, s[23:20]);
      s = s << 4;
      if (i < int'(v.len) - 1) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) out_tab[i] = '0;
    //                  pcw pcwc jr iord mr mw irw m2r rd rw asa asb    aop    pcs
    out_tab[1]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00);
    out_tab[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00);
    out_tab[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00);
    out_tab[4]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00);
    out_tab[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00);
    out_tab[6]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00);
    out_tab[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00);
    out_tab[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00);
    out_tab[9]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01);
    out_tab[10] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10);
    out_tab[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11);
    out_tab[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00);
    out_tab[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00);

    //               op         funct      len   state sequence
    vecs[0] = '{6'b100011, 6'b000000, 4'd6, 24'h123451};  // lw
    vecs[1] = '{6'b101011, 6'b000000, 4'd5, 24'h123610};  // sw
    vecs[2] = '{6'b000000, 6'b100000, 4'd5, 24'h127810};  // R-type add
    vecs[3] = '{6'b000000, 6'b001000, 4'd4, 24'h12B100};  // jr
    vecs[4] = '{6'b000100, 6'b000000, 4'd4, 24'h129100};  // beq
    vecs[5] = '{6'b000010, 6'b000000, 4'd4, 24'h12A100};  // j
    vecs[6] = '{6'b001000, 6'b000000, 4'd5, 24'h12CD10};  // addi
    vecs[7] = '{6'b001000, 6'b001000, 4'd5, 24'h12CD10};  // addi, Funct looks like jr
    vecs[8] = '{6'b111111, 6'b001000, 4'd3, 24'h121000};  // undefined opcode

    reset = 1'b1;
    Op    = 6'b000000;
    Funct = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", 4'd0);
    end
    reset = 1'b0;
    check("post_release", 4'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // sw interrupted by reset while in MEMWR
    Op    = 6'b101011;
    Funct = 6'b000000;
    check("sw_fetch", 4'd1);
    @(negedge clk); check("sw_decode", 4'd2);
    @(negedge clk); check("sw_memadr", 4'd3);
    @(negedge clk); check("sw_memwr", 4'd6);
    #2 reset = 1'b1;
    #1 check("async_reset", 4'd0);
    @(negedge clk); check("reset_held", 4'd0);
    reset = 1'b0;
    check("reset_release", 4'd0);
    @(negedge clk); check("resume_fetch", 4'd1);

    run_vec("lw_after_reset", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
